// File: rtl/cmp_scan_disp.sv
// cmp_scan_disp: compares two unsigned operands and shows max/min in hex on a
// six-digit multiplexed seven-segment display, with a relation glyph on digit 5.
// Optional build macro: CMP_LZB_EN enables leading-zero blanking on value digits.
module cmp_scan_disp #(
    parameter int DATA_W   = 8,
    parameter int SCAN_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] ina,
    input  logic [DATA_W-1:0] inb,
    input  logic              mode,
    input  logic              hold,
    output logic              lt,
    output logic              gt,
    output logic              eq,
    output logic [7:0]        seg,
    output logic [5:0]        sel
);

    localparam int             NIB      = DATA_W / 4;
    localparam int             CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [2:0]     NIB_L    = 3'(NIB);
    localparam logic [2:0]     REL_DIG  = 3'd5;

    logic [DATA_W-1:0] ra;
    logic [DATA_W-1:0] rb;
    logic [DATA_W-1:0] val;
    logic [CW-1:0]     cnt;
    logic              tick;
    logic [2:0]        dig;
    logic [2:0]        dig_nxt;
    logic [3:0]        nib;
    logic [7:0]        glyph;
    logic [5:0]        sel_nxt;

    function automatic logic [7:0] hex_glyph(input logic [3:0] n);
        case (n)
            4'h0: hex_glyph = 8'hC0;
            4'h1: hex_glyph = 8'hF9;
            4'h2: hex_glyph = 8'hA4;
            4'h3: hex_glyph = 8'hB0;
            4'h4: hex_glyph = 8'h99;
            4'h5: hex_glyph = 8'h92;
            4'h6: hex_glyph = 8'h82;
            4'h7: hex_glyph = 8'hF8;
            4'h8: hex_glyph = 8'h80;
            4'h9: hex_glyph = 8'h90;
            4'hA: hex_glyph = 8'h88;
            4'hB: hex_glyph = 8'h83;
            4'hC: hex_glyph = 8'hC6;
            4'hD: hex_glyph = 8'hA1;
            4'hE: hex_glyph = 8'h86;
            default: hex_glyph = 8'h8E;
        endcase
    endfunction

    // Operand sampling; hold freezes the last sampled pair
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra <= '0;
            rb <= '0;
        end else if (!hold) begin
            ra <= ina;
            rb <= inb;
        end
    end

    // Registered compare flags and max/min selection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lt  <= 1'b0;
            gt  <= 1'b0;
            eq  <= 1'b0;
            val <= '0;
        end else begin
            lt <= (ra < rb);
            gt <= (ra > rb);
            eq <= (ra == rb);
            if (mode) val <= (ra < rb) ? ra : rb;
            else      val <= (ra > rb) ? ra : rb;
        end
    end

    // Scan divider: one tick per digit slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= tick ? '0 : cnt + 1'b1;
    end

    assign tick = (cnt == CNT_LAST);

    // Pattern for the digit about to be lit; only sampled on tick so a slot never changes mid-way
    always_comb begin
        dig_nxt = (dig == REL_DIG) ? 3'd0 : dig + 3'd1;
        nib     = 4'(val >> {dig_nxt, 2'b00});
        sel_nxt = ~(6'b000001 << dig_nxt);
        glyph   = 8'hFF;
        if (dig_nxt == REL_DIG) begin
            if (gt)      glyph = 8'h88;
            else if (lt) glyph = 8'h83;
            else if (eq) glyph = 8'hB7;
        end else if (dig_nxt < NIB_L) begin
            glyph = hex_glyph(nib);
`ifdef CMP_LZB_EN
            if ((dig_nxt != 3'd0) && ((val >> {dig_nxt, 2'b00}) == '0)) glyph = 8'hFF;
`endif
        end
    end

    // Digit index and segment/select registers, advanced once per slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig <= REL_DIG;
            seg <= 8'hFF;
            sel <= 6'h3F;
        end else if (tick) begin
            dig <= dig_nxt;
            seg <= glyph;
            sel <= sel_nxt;
        end
    end

endmodule

// File: tb/tb_cmp_scan_disp.sv
// tb_cmp_scan_disp: directed and random checks of cmp_scan_disp (DATA_W=8, SCAN_DIV=4)
// against a cycle-count-based reference model. Honors CMP_LZB_EN when defined.
module tb_cmp_scan_disp;

    localparam int DW  = 8;
    localparam int SD  = 4;
    localparam int NIB = DW / 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] ina, inb;
    logic          mode, hold;
    logic          lt, gt, eq;
    logic [7:0]    seg;
    logic [5:0]    sel;

    int tests = 0;
    int fails = 0;

    cmp_scan_disp #(.DATA_W(DW), .SCAN_DIV(SD)) dut (
        .clk(clk), .rst_n(rst_n), .ina(ina), .inb(inb), .mode(mode), .hold(hold),
        .lt(lt), .gt(gt), .eq(eq), .seg(seg), .sel(sel)
    );

    always #5 clk = ~clk;

    logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Expected segment pattern for digit d showing value v with the given relation
    function automatic logic [7:0] exp_glyph(input int d, input int v, input logic l, input logic g, input logic e);
        if (d == 5) return g ? 8'h88 : l ? 8'h83 : e ? 8'hB7 : 8'hFF;
        if (d >= NIB) return 8'hFF;
`ifdef CMP_LZB_EN
        if (d > 0 && (v / (1 << (4 * d))) == 0) return 8'hFF;
`endif
        return hex_tab[(v >> (4 * d)) % 16];
    endfunction

    // Reference model: digit slot derived from the number of edges since reset
    int         m_cyc;
    int         m_ra, m_rb, m_val;
    logic       m_lt, m_gt, m_eq;
    logic [7:0] m_seg;
    logic [5:0] m_sel;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc <= 0; m_ra <= 0; m_rb <= 0; m_val <= 0;
            m_lt <= 1'b0; m_gt <= 1'b0; m_eq <= 1'b0;
            m_seg <= 8'hFF; m_sel <= 6'h3F;
        end else begin
            m_cyc <= m_cyc + 1;
            if ((m_cyc + 1) % SD == 0) begin
                m_seg <= exp_glyph(((m_cyc + 1) / SD - 1) % 6, m_val, m_lt, m_gt, m_eq);
                m_sel <= 6'h3F & ~(6'h01 << (((m_cyc + 1) / SD - 1) % 6));
            end
            m_lt  <= m_ra < m_rb;
            m_gt  <= m_ra > m_rb;
            m_eq  <= m_ra == m_rb;
            m_val <= mode ? ((m_ra < m_rb) ? m_ra : m_rb) : ((m_ra > m_rb) ? m_ra : m_rb);
            if (!hold) begin
                m_ra <= int'(ina);
                m_rb <= int'(inb);
            end
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("seg", seg, m_seg);
        chk("sel", {2'b00, sel}, {2'b00, m_sel});
        chk("flags", {5'b0, lt, gt, eq}, {5'b0, m_lt, m_gt, m_eq});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_all();
        end
    endtask

    // Wait for the next fresh slot of digit d and compare its pattern
    task automatic show_digit(input int d, input logic [7:0] exp, input string tag);
        logic [5:0] want;
        bit         ok;
        want = 6'h3F & ~(6'h01 << d);
        for (int i = 0; i < 8 * SD && sel === want; i++) begin
            @(negedge clk);
            check_all();
        end
        ok = 1'b0;
        for (int i = 0; i < 8 * SD; i++) begin
            @(negedge clk);
            check_all();
            if (sel === want) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $error("FAIL %s: digit %0d never selected, sel %h", tag, d, sel);
        end else begin
            chk(tag, seg, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; ina = '0; inb = '0; mode = 1'b0; hold = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_seg", seg, 8'hFF);
        chk("rst_sel", {2'b00, sel}, 8'h3F);
        chk("rst_flags", {5'b0, lt, gt, eq}, 8'h00);
        rst_n = 1'b1;

        for (int k = 1; k <= SD; k++) begin
            @(negedge clk);
            check_all();
            if (k == 2) chk("eq_cycle2", {7'b0, eq}, 8'h01);
            if (k < SD) chk("pre_tick_sel", {2'b00, sel}, 8'h3F);
            else begin
                chk("first_tick_sel", {2'b00, sel}, 8'h3E);
                chk("first_tick_seg", seg, 8'hC0);
            end
        end

        ina = 8'h3C; inb = 8'h5A; mode = 1'b0;
        repeat (2) @(negedge clk);
        chk("lt_after2", {5'b0, lt, gt, eq}, 8'h04);
        run(7 * SD);
        show_digit(0, 8'h88, "max_d0");
        show_digit(1, 8'h92, "max_d1");
        show_digit(2, 8'hFF, "max_d2");
        show_digit(4, 8'hFF, "max_d4");
        show_digit(5, 8'h83, "max_d5");

        mode = 1'b1;
        run(7 * SD);
        show_digit(0, 8'hC6, "min_d0");
        show_digit(1, 8'hB0, "min_d1");
        show_digit(5, 8'h83, "min_d5");

        hold = 1'b1; ina = 8'hFF;
        for (int f = 0; f < 3; f++) begin
            run(6 * SD);
            chk("hold_flags", {5'b0, lt, gt, eq}, 8'h04);
        end
        show_digit(0, 8'hC6, "hold_d0");
        hold = 1'b0;
        repeat (2) @(negedge clk);
        chk("release_gt", {5'b0, lt, gt, eq}, 8'h02);
        show_digit(5, 8'h88, "release_d5");

        ina = 8'h07; inb = 8'h07; mode = 1'b0;
        run(7 * SD);
        show_digit(0, 8'hF8, "eq_d0");
`ifdef CMP_LZB_EN
        show_digit(1, 8'hFF, "lzb_d1");
`else
        show_digit(1, 8'hC0, "nolzb_d1");
`endif
        show_digit(5, 8'hB7, "eq_d5");

        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            check_all();
            ina  = 8'($urandom);
            inb  = ($urandom_range(0, 3) == 0) ? ina : 8'($urandom);
            mode = 1'($urandom);
            hold = ($urandom_range(0, 4) == 0);
        end
        hold = 1'b0;

        show_digit(3, m_seg, "pre_reset_d3");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_seg", seg, 8'hFF);
        chk("async_sel", {2'b00, sel}, 8'h3F);
        chk("async_flags", {5'b0, lt, gt, eq}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= SD; k++) begin
            @(negedge clk);
            check_all();
            if (k < SD) chk("restart_off", {2'b00, sel}, 8'h3F);
            else        chk("restart_d0", {2'b00, sel}, 8'h3E);
        end
        run(6 * SD);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
